// File: rtl/rr_decode_grant_sched.sv
// Round-robin scheduler: registers a binary grant index plus enable and decodes them into a one-hot grant.
// Optional build macro RRSCHED_TIMEOUT_EN adds a hold counter that revokes a grant after MAX_HOLD cycles.
module rr_decode_grant_sched #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx_nxt;
    logic [N-1:0]     onehot_nxt;
    logic             found;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             release_now;
    logic             hold_hit;

    // Search from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int cand;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

`ifdef RRSCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Counter is zero on the first GRANT cycle and counts GRANT cycles from there.
    always_ff @(posedge clk) begin
        if (rst || state != GRANT) begin
            hold_cnt <= '0;
        end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign hold_hit = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    // No hold limit in this build; MAX_HOLD == 0 is not a legal setting.
    assign hold_hit = (MAX_HOLD == 0);
`endif

    assign release_now = done || !req[gnt_idx] || hold_hit;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        valid_nxt   = 1'b0;
        idx_nxt     = gnt_idx;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    valid_nxt = 1'b1;
                    idx_nxt   = winner;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt   = GAP;
                    ptr_nxt     = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    timeout_nxt = hold_hit && !done && req[gnt_idx];
                end else begin
                    valid_nxt = 1'b1;
                end
            end
            GAP: begin
                if (found) begin
                    state_nxt = GRANT;
                    valid_nxt = 1'b1;
                    idx_nxt   = winner;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        onehot_nxt = valid_nxt ? (N'(1) << idx_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt_valid  <= valid_nxt;
            gnt_idx    <= idx_nxt;
            gnt_onehot <= onehot_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_decode_grant_sched.sv
// Scoreboard bench for rr_decode_grant_sched: stimulus queues expected grant starts and timeout pulses,
// a negedge monitor pops and compares them and checks the one-hot decode every cycle.
module tb_rr_decode_grant_sched;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic [N-1:0]     req;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic             timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int idx;
        int at;
    } grant_t;

    grant_t exp_q[$];
    int     to_q[$];

    logic             prev_valid = 1'b0;
    logic [IDX_W-1:0] prev_idx   = '0;

    rr_decode_grant_sched #(
        .N(N),
        .IDX_W(IDX_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_onehot(gnt_onehot),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [N-1:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectGrant(input int idx, input int at);
        grant_t g;
        g.idx = idx;
        g.at  = at;
        exp_q.push_back(g);
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [IDX_W-1:0] i,
                               input logic [N-1:0] oh, input logic to);
        checks++;
        if (gnt_valid !== v || gnt_idx !== i || gnt_onehot !== oh || timeout !== to) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b idx=%0d onehot=%b timeout=%b, expected valid=%b idx=%0d onehot=%b timeout=%b",
                     name, gnt_valid, gnt_idx, gnt_onehot, timeout, v, i, oh, to);
        end
    endtask

    // Monitor: decode invariant, timeout pulses, owner stability and grant starts against the queue.
    always @(negedge clk) begin
        logic [N-1:0] ref_oh;
        logic         exp_to;
        grant_t       g;
        ref_oh = (gnt_valid === 1'b1) ? (N'(1) << gnt_idx) : '0;
        checks++;
        if (!$onehot0(gnt_onehot) || gnt_onehot !== ref_oh) begin
            failures++;
            $display("[TB] FAIL decode at cycle %0d: got onehot=%b, expected %b", cyc, gnt_onehot, ref_oh);
        end
        exp_to = (to_q.size() > 0) && (to_q[0] == cyc);
        if (exp_to) begin
            void'(to_q.pop_front());
        end
        checks++;
        if (timeout !== exp_to) begin
            failures++;
            $display("[TB] FAIL timeout at cycle %0d: got %b, expected %b", cyc, timeout, exp_to);
        end
        if (gnt_valid === 1'b1 && prev_valid) begin
            checks++;
            if (gnt_idx !== prev_idx) begin
                failures++;
                $display("[TB] FAIL hold at cycle %0d: got idx=%0d, expected %0d", cyc, gnt_idx, prev_idx);
            end
        end
        if (gnt_valid === 1'b1 && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL grant at cycle %0d: got unexpected idx=%0d, expected no grant", cyc, gnt_idx);
            end else begin
                g = exp_q.pop_front();
                if (gnt_idx !== g.idx || cyc != g.at) begin
                    failures++;
                    $display("[TB] FAIL grant: got idx=%0d at cycle %0d, expected idx=%0d at cycle %0d",
                             gnt_idx, cyc, g.idx, g.at);
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            g = exp_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missed grant: got none by cycle %0d, expected idx=%0d at cycle %0d", cyc, g.idx, g.at);
        end
        prev_valid = (gnt_valid === 1'b1);
        prev_idx   = gnt_idx;
    end

    initial begin
        // Reset with all requesting, then first grant one edge after release.
        applyStimulus(4'b1111, 1'b0, 1'b1);
        stepCycles(2);
        checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        expectGrant(0, cyc + 1);
        stepCycles(1);

        // Rotation 0,1,2,3,0 with a done pulse in each grant and one dead cycle between.
        for (int i = 0; i < 4; i++) begin
            done = 1'b1;
            expectGrant((i + 1) % 4, cyc + 2);
            stepCycles(1);
            done = 1'b0;
            stepCycles(1);
        end

        // Withdrawals: owner hand-offs including the wrap from 3 to 0.
        req = 4'b0100; expectGrant(2, cyc + 2); stepCycles(2);
        req = 4'b1000; expectGrant(3, cyc + 2); stepCycles(2);
        req = 4'b0100; expectGrant(2, cyc + 2); stepCycles(2);
        req = 4'b0001; expectGrant(0, cyc + 2); stepCycles(2);

        // Late request waits; done in GRANT releases, done held into GAP is ignored.
        req = 4'b0011;
        stepCycles(3);
        done = 1'b1;
        expectGrant(1, cyc + 2);
        stepCycles(2);
        done = 1'b0;

        // Owner 3 active, then mid-grant reset restores ptr to 0.
        req = 4'b1000; expectGrant(3, cyc + 2); stepCycles(4);
        applyStimulus(4'b1010, 1'b0, 1'b1);
        stepCycles(1);
        checkOutput("mid-grant reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        expectGrant(1, cyc + 1);
        stepCycles(1);

        // done while in GAP and IDLE has no effect; fresh request from IDLE.
        req = 4'b0000;
        stepCycles(1);
        done = 1'b1;
        stepCycles(2);
        done = 1'b0;
        req  = 4'b0100;
        expectGrant(2, cyc + 1);
        stepCycles(1);

        // Owner 1 holds with no done while requester 2 waits.
        req = 4'b0010; expectGrant(1, cyc + 2); stepCycles(2);
        req = 4'b0110;
`ifdef RRSCHED_TIMEOUT_EN
        to_q.push_back(cyc + 16);
        expectGrant(2, cyc + 17);
        stepCycles(17);
        req = 4'b0100;
        stepCycles(15);
        done = 1'b1;
        stepCycles(1);
        done = 1'b0;
        req  = 4'b0000;
        stepCycles(3);
`else
        stepCycles(110);
        checkOutput("long hold", 1'b1, 2'd1, 4'b0010, 1'b0);
        done = 1'b1;
        expectGrant(2, cyc + 2);
        stepCycles(1);
        done = 1'b0;
        stepCycles(1);
        req = 4'b0000;
        stepCycles(3);
`endif

        checks++;
        if (exp_q.size() != 0 || to_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d grants and %0d timeouts outstanding, expected 0 and 0",
                     exp_q.size(), to_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
